iq_integrator: RTL

- Demodulation integrator directly upstream of analyze_fsm.
- Takes the I stream (ADC channel 0) and Q stream (ADC channel 1) at 5 samples per clk100 cycle.
- On a trigger rising edge it skips a configurable number of beats, then integrates a configurable window of beats.
- It then emits one scaled signed I/Q point as i_val/q_val with a single-cycle iq_valid pulse, which is the point format analyze_fsm consumes.

---
 rtl/iq_integrator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/iq_integrator.sv
// I/Q demodulation integrator: after a trigger edge, skips a beat delay, then
// integrates a window of 5-sample beats per channel and emits one scaled point.
module iq_integrator #(
  parameter int SPC = 5,
  parameter int DW  = 16,
  parameter int AW  = 32
) (
  input  logic          clk100,
  input  logic          reset,
  input  logic [DW-1:0] data0_in_0,
  input  logic [DW-1:0] data0_in_1,
  input  logic [DW-1:0] data0_in_2,
  input  logic [DW-1:0] data0_in_3,
  input  logic [DW-1:0] data0_in_4,
  input  logic [DW-1:0] data1_in_0,
  input  logic [DW-1:0] data1_in_1,
  input  logic [DW-1:0] data1_in_2,
  input  logic [DW-1:0] data1_in_3,
  input  logic [DW-1:0] data1_in_4,
  input  logic          in_valid,
  input  logic          trigger,
  input  logic [15:0]   delay_beats,
  input  logic [15:0]   window_beats,
  input  logic [4:0]    out_shift,
  output logic          busy,
  output logic          iq_valid,
  output logic [AW-1:0] i_val,
  output logic [AW-1:0] q_val,
  output logic          saturated,
  output logic          trigger_missed
);

  // Exact width of a sum of SPC sign-extended samples.
  localparam int SW = DW + $clog2(SPC);

  typedef enum logic [1:0] {IDLE, DELAY, INTEGRATE} state_t;

  state_t        state;
  logic          trigD;
  logic          trigEdge;
  logic [15:0]   delayLat;
  logic [15:0]   windowLat;
  logic [4:0]    shiftLat;
  logic [15:0]   dCnt;
  logic [15:0]   wCnt;
  logic [AW-1:0] accI;
  logic [AW-1:0] accQ;
  logic          sticky;

  logic [DW-1:0] iS [SPC];
  logic [DW-1:0] qS [SPC];
  logic [SW-1:0] sumI;
  logic [SW-1:0] sumQ;
  logic [AW+1:0] addI;
  logic [AW+1:0] addQ;
  logic [AW:0]   satI;
  logic [AW:0]   satQ;
  logic signed [AW-1:0] resI;
  logic signed [AW-1:0] resQ;
  logic [AW-1:0] shI;
  logic [AW-1:0] shQ;

  assign iS[0] = data0_in_0;
  assign iS[1] = data0_in_1;
  assign iS[2] = data0_in_2;
  assign iS[3] = data0_in_3;
  assign iS[4] = data0_in_4;
  assign qS[0] = data1_in_0;
  assign qS[1] = data1_in_1;
  assign qS[2] = data1_in_2;
  assign qS[3] = data1_in_3;
  assign qS[4] = data1_in_4;

  assign trigEdge = trigger & ~trigD;

  always_comb begin
    sumI = '0;
    sumQ = '0;
    for (int unsigned k = 0; k < SPC; k++) begin
      sumI = sumI + {{(SW-DW){iS[k][DW-1]}}, iS[k]};
      sumQ = sumQ + {{(SW-DW){qS[k][DW-1]}}, qS[k]};
    end
  end

  // Returns {clip, clamped value}; the two guard bits expose any overflow.
  function automatic logic [AW:0] sat32(input logic [AW+1:0] v);
    if ((v[AW+1:AW-1] == 3'b000) || (v[AW+1:AW-1] == 3'b111))
      return {1'b0, v[AW-1:0]};
    else if (v[AW+1])
      return {1'b1, 1'b1, {(AW-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(AW-1){1'b1}}};
  endfunction

  assign addI = {{2{accI[AW-1]}}, accI} + {{(AW+2-SW){sumI[SW-1]}}, sumI};
  assign addQ = {{2{accQ[AW-1]}}, accQ} + {{(AW+2-SW){sumQ[SW-1]}}, sumQ};
  assign satI = sat32(addI);
  assign satQ = sat32(addQ);
  assign resI = satI[AW-1:0];
  assign resQ = satQ[AW-1:0];
  assign shI  = resI >>> shiftLat;
  assign shQ  = resQ >>> shiftLat;

  always_ff @(posedge clk100) begin
    if (!reset) begin
      state          <= IDLE;
      trigD          <= 1'b0;
      delayLat       <= '0;
      windowLat      <= '0;
      shiftLat       <= '0;
      dCnt           <= '0;
      wCnt           <= '0;
      accI           <= '0;
      accQ           <= '0;
      sticky         <= 1'b0;
      busy           <= 1'b0;
      iq_valid       <= 1'b0;
      i_val          <= '0;
      q_val          <= '0;
      saturated      <= 1'b0;
      trigger_missed <= 1'b0;
    end else begin
      trigD          <= trigger;
      iq_valid       <= 1'b0;
      trigger_missed <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the result cycle, then follows new edges.
          busy <= trigEdge;
          if (trigEdge) begin
            delayLat  <= delay_beats;
            windowLat <= (window_beats == 16'd0) ? 16'd1 : window_beats;
            shiftLat  <= out_shift;
            dCnt      <= '0;
            wCnt      <= '0;
            accI      <= '0;
            accQ      <= '0;
            sticky    <= 1'b0;
            state     <= (delay_beats == 16'd0) ? INTEGRATE : DELAY;
          end
        end
        DELAY: begin
          if (trigEdge) trigger_missed <= 1'b1;
          if (in_valid) begin
            dCnt <= dCnt + 16'd1;
            if ((dCnt + 16'd1) == delayLat) state <= INTEGRATE;
          end
        end
        INTEGRATE: begin
          if (trigEdge) trigger_missed <= 1'b1;
          if (in_valid) begin
            accI   <= satI[AW-1:0];
            accQ   <= satQ[AW-1:0];
            sticky <= sticky | satI[AW] | satQ[AW];
            wCnt   <= wCnt + 16'd1;
            if ((wCnt + 16'd1) == windowLat) begin
              i_val     <= shI;
              q_val     <= shQ;
              saturated <= sticky | satI[AW] | satQ[AW];
              iq_valid  <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
